// File: rtl/deserializador.sv
// Serial-to-parallel front end for the byte queue.
// Assembles MSB-first bytes and pushes them with a one-cycle enqueue pulse.
module deserializador #(
  parameter int QUEUE_DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic [7:0] len_in,
  output logic [7:0] data_out,
  output logic       enqueue_out,
  output logic       status_out
);

  localparam logic [1:0] S_RECEIVE = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_PUSH    = 2'd2;

  localparam logic [8:0] LP_DEPTH = 9'(QUEUE_DEPTH);

  logic [1:0] r_state;
  logic [7:0] r_sh;
  logic [2:0] r_cnt;
  logic [7:0] r_data;

  logic w_room;
  logic w_take;

  // Occupancy above the depth also reads as full.
  assign w_room = ({1'b0, len_in} < LP_DEPTH);
  assign w_take = (r_state == S_RECEIVE) && write_in;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_RECEIVE;
      r_sh    <= 8'h00;
      r_cnt   <= 3'd0;
      r_data  <= 8'h00;
    end else begin
      unique case (r_state)
        S_RECEIVE: begin
          if (w_take) begin
            r_sh  <= {r_sh[6:0], data_in};
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7)
              r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_room) begin
            r_data  <= r_sh;
            r_state <= S_PUSH;
          end
        end
        S_PUSH: begin
          r_state <= S_RECEIVE;
        end
        default: begin
          r_state <= S_RECEIVE;
        end
      endcase
    end
  end

  assign data_out    = r_data;
  assign enqueue_out = (r_state == S_PUSH);
  assign status_out  = (r_state == S_RECEIVE);

endmodule

// File: tb/tb_deserializador.sv
// Bench for deserializador: expected bytes queued at stimulus time,
// popped and compared whenever the DUT raises enqueue_out.
module tb_deserializador;

  logic       clock = 1'b0;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic [7:0] len_in;
  logic [7:0] data_out;
  logic       enqueue_out;
  logic       status_out;

  always #5 clock = ~clock;

  deserializador #(.QUEUE_DEPTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .write_in    (write_in),
    .len_in      (len_in),
    .data_out    (data_out),
    .enqueue_out (enqueue_out),
    .status_out  (status_out)
  );

  int         n_vec   = 0;
  int         n_err   = 0;
  int         cyc     = 0;
  int         n_pulse = 0;
  logic [7:0] sb[$];
  int         pt[$];
  logic [7:0] mon_exp;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (enqueue_out === 1'b1) begin
      n_pulse++;
      pt.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexp_pulse", 32'd1, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("byte", {24'd0, data_out}, {24'd0, mon_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 7; i >= 0; i--) begin
      data_in  = b[i];
      write_in = 1'b1;
      tick();
      if (gap > 0 && i > 0) begin
        write_in = 1'b0;
        repeat (gap) tick();
      end
    end
    write_in = 1'b0;
  endtask

  int         p0;
  int         nb;
  logic [7:0] m;

  initial begin
    reset    = 1'b1;
    write_in = 1'b0;
    data_in  = 1'b0;
    len_in   = 8'd0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_data", {24'd0, data_out}, 32'h00);
    chk("rst_enq", {31'd0, enqueue_out}, 32'd0);
    chk("rst_st", {31'd0, status_out}, 32'd1);

    // basic byte, queue empty
    sb.push_back(8'hA5);
    p0 = n_pulse;
    send_byte(8'hA5, 0);
    chk("t1_wait_st", {31'd0, status_out}, 32'd0);
    chk("t1_wait_enq", {31'd0, enqueue_out}, 32'd0);
    tick();
    chk("t1_push_enq", {31'd0, enqueue_out}, 32'd1);
    chk("t1_push_st", {31'd0, status_out}, 32'd0);
    chk("t1_data", {24'd0, data_out}, 32'hA5);
    tick();
    chk("t1_rx_st", {31'd0, status_out}, 32'd1);
    chk("t1_rx_enq", {31'd0, enqueue_out}, 32'd0);
    chk("t1_npulse", n_pulse - p0, 32'd1);

    // queue full, then over-full, then room
    len_in = 8'd8;
    sb.push_back(8'hA5);
    p0 = n_pulse;
    send_byte(8'hA5, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t2_full_enq", {31'd0, enqueue_out}, 32'd0);
      chk("t2_full_st", {31'd0, status_out}, 32'd0);
    end
    len_in = 8'd200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_over_enq", {31'd0, enqueue_out}, 32'd0);
    end
    len_in = 8'd7;
    tick();
    chk("t2_push_enq", {31'd0, enqueue_out}, 32'd1);
    chk("t2_data", {24'd0, data_out}, 32'hA5);
    tick();
    chk("t2_rx_st", {31'd0, status_out}, 32'd1);
    chk("t2_npulse", n_pulse - p0, 32'd1);
    len_in = 8'd0;

    // strobes during WAIT/PUSH are dropped
    sb.push_back(8'hFF);
    sb.push_back(8'h3C);
    p0 = n_pulse;
    send_byte(8'hFF, 0);
    data_in  = 1'b0;
    write_in = 1'b1;
    tick();
    tick();
    write_in = 1'b0;
    send_byte(8'h3C, 0);
    tick();
    tick();
    chk("t3_npulse", n_pulse - p0, 32'd2);
    chk("t3_data", {24'd0, data_out}, 32'h3C);

    // mid-byte reset discards partial bits
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) begin
      data_in  = 1'b1;
      write_in = 1'b1;
      tick();
    end
    write_in = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_rst_data", {24'd0, data_out}, 32'h00);
    chk("t4_rst_st", {31'd0, status_out}, 32'd1);
    chk("t4_rst_enq", {31'd0, enqueue_out}, 32'd0);
    repeat (4) tick();
    chk("t4_nopulse", n_pulse - p0, 32'd0);
    sb.push_back(8'h81);
    send_byte(8'h81, 0);
    tick();
    tick();
    chk("t4_npulse", n_pulse - p0, 32'd1);

    // reset during PUSH cuts the pulse
    sb.push_back(8'hC3);
    send_byte(8'hC3, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_enq", {31'd0, enqueue_out}, 32'd0);
    chk("t5_st", {31'd0, status_out}, 32'd1);
    chk("t5_data", {24'd0, data_out}, 32'h00);

    // sparse strobes
    sb.push_back(8'h5A);
    p0 = n_pulse;
    send_byte(8'h5A, 2);
    tick();
    tick();
    chk("t6_npulse", n_pulse - p0, 32'd1);
    chk("t6_data", {24'd0, data_out}, 32'h5A);

    // continuous random stream, 10-cycle byte period
    p0 = n_pulse;
    pt.delete();
    nb = 0;
    m  = 8'h00;
    for (int i = 0; i < 30; i++) begin
      data_in  = 1'($urandom_range(0, 1));
      write_in = 1'b1;
      if ((i % 10) < 8) begin
        m = {m[6:0], data_in};
        nb++;
        if (nb == 8) begin
          sb.push_back(m);
          nb = 0;
        end
      end
      tick();
    end
    write_in = 1'b0;
    repeat (3) tick();
    chk("t7_npulse", n_pulse - p0, 32'd3);
    if (pt.size() == 3) begin
      chk("t7_gap1", pt[1] - pt[0], 32'd10);
      chk("t7_gap2", pt[2] - pt[1], 32'd10);
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
